tl_ul_sram_responder: RTL and testbench
=======================================

// Module: tl_ul_sram_responder
// PURPOSE
//  TileLink-UL responder (manager end) for the A-channel traffic checked by the bus monitor.
//  - Accepts single-beat Get/PutFull/PutPartial on A; services them from a small word-organised SRAM.
//  - Returns AccessAck/AccessAckData on D through a 2-entry response queue; illegal requests get a denied ack.
// PARAMETERS
//  ADDR_W     14  A-channel address width (byte address)
//  DATA_W     32  data bus width; mask width = DATA_W/8
//  SOURCE_W    5  source ID width, echoed on D
//  MEM_WORDS  64  SRAM depth in DATA_W words; bytes 0 .. MEM_WORDS*DATA_W/8-1 are backed
// PORTS
//  clock      in   1         sole clock, all state on rising edge
//  reset_n    in   1         asynchronous active-low reset
//  a_valid    in   1         A request valid
//  a_ready    out  1         A request accepted when a_valid & a_ready
//  a_opcode   in   3         0 PutFull, 1 PutPartial, 4 Get, 2/3/5 Arith/Logic/Hint
//  a_param    in   3         must be 0
//  a_size     in   3         log2 bytes; legal 0..2
//  a_source   in   SOURCE_W  requester ID
//  a_address  in   ADDR_W    byte address
//  a_mask     in   DATA_W/8  byte lanes
//  a_data     in   DATA_W    write data
//  a_corrupt  in   1         write data poisoned
//  d_valid    out  1         D response valid
//  d_ready    in   1         D response consumed when d_valid & d_ready
//  d_opcode   out  3         0 AccessAck, 1 AccessAckData, 2 HintAck
//  d_param    out  2         always 0
//  d_size     out  3         echo of a_size
//  d_source   out  SOURCE_W  echo of a_source
//  d_sink     out  1         always 0
//  d_denied   out  1         request rejected
//  d_data     out  DATA_W    read data (0 when not AccessAckData or denied)
//  d_corrupt  out  1         equals d_denied on AccessAckData, else 0
// BEHAVIOUR
//  - Reset: queue empty; d_valid=0, all d_* fields 0, a_ready=1. SRAM contents not reset.
//    Reset asserted mid-operation drops queued responses; a request in flight is not acked.
//  - a_ready = queue count < 2 (no bypass when full, even with d_ready=1). Enqueue and dequeue in the same cycle are legal at count 1.
//  - Latency: A fire in cycle N -> response at D head in N+1 if queue was empty. Sustained throughput 1 req/cycle.
//  - D holds all fields stable while d_valid & !d_ready. Responses are issued strictly in A order.
//  - Denied when any of: a_param!=0; a_size>2; a_address not aligned to 2^a_size; word index >= MEM_WORDS;
//    PutFull/Get mask != exact lane mask implied by size/address; PutPartial mask has lanes outside that;
//    Put with a_corrupt=1; opcode 2/3/6/7; opcode 5 when the macro is off.
//  - Put (not denied): byte lanes with mask=1 written at the A fire edge; response AccessAck, denied=0.
//  - Get (not denied): word read at the A fire edge, value captured in the queue entry (a Put fired the
//    previous cycle is visible; the queued value is unaffected by later Puts). Response AccessAckData.
//  - Denied: no SRAM write; d_opcode = AccessAckData for Get, else AccessAck; d_denied=1, d_data=0.
//  - Index = a_address[ADDR_W-1:log2(DATA_W/8)]; upper bits beyond MEM_WORDS range are checked, never wrapped.
// CONFIGURATION
//  TL_RESP_HINT_EN defined: Hint (opcode 5, a_param 0 or 1, other checks as Get) -> HintAck, denied=0, no SRAM access.
//  Undefined: Hint -> AccessAck with d_denied=1.
// STRUCTURE
//  - Package tl_ul_pkg: A/D opcode constants, response-entry struct {opcode,size,source,denied,data}, lane-mask function.
//  - Sub-module tl_resp_queue: 2-entry FIFO of response entries, valid/ready both sides, async active-low reset.
//  - Top: request decode/legality, SRAM array, enqueue logic.
// TESTING
//  - Reset: reset_n=0 mid-traffic with 2 queued -> d_valid=0 next cycle, a_ready=1 after release.
//  - PutFull addr 0x10 size 2 mask 0xF data 0xDEADBEEF, then Get 0x10 -> AccessAck then AccessAckData 0xDEADBEEF, sources echoed.
//  - PutPartial 0x10 mask 0x2 data 0x0000AA00, Get 0x10 -> 0xDEADAAEF.
//  - Get 0x100 (index 64) -> AccessAckData, denied=1, corrupt=1, data 0; Get 0x11 size 1 -> denied.
//  - Back-to-back 4 Gets with d_ready=0 -> a_ready drops after 2 accepted; release d_ready -> 4 responses in order.
//  - Hint opcode 5 -> HintAck denied=0 with TL_RESP_HINT_EN; AccessAck denied=1 without.

Source files
------------

// File: rtl/tl_ul_pkg.sv
// TileLink-UL responder shared types: A/D opcodes, queued response entry, lane masks.
// Shared by tl_resp_queue and tl_ul_sram_responder.
package tl_ul_pkg;

  localparam int TL_DATA_W    = 32;
  localparam int TL_SOURCE_W  = 5;
  localparam int TL_MAX_LANES = 16;

  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_ARITH       = 3'd2;
  localparam logic [2:0] A_LOGIC       = 3'd3;
  localparam logic [2:0] A_GET         = 3'd4;
  localparam logic [2:0] A_HINT        = 3'd5;

  localparam logic [2:0] D_ACK      = 3'd0;
  localparam logic [2:0] D_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK = 3'd2;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [2:0]             size;
    logic [TL_SOURCE_W-1:0] source;
    logic                   denied;
    logic [TL_DATA_W-1:0]   data;
  } tl_rsp_t;

  // Byte lanes covered by a 2^size access starting at lane offs.
  function automatic logic [TL_MAX_LANES-1:0] lane_mask(
    input logic [2:0] size,
    input logic [3:0] offs
  );
    logic [TL_MAX_LANES-1:0] m;
    case (size)
      3'd0:    m = 16'h0001;
      3'd1:    m = 16'h0003;
      3'd2:    m = 16'h000F;
      3'd3:    m = 16'h00FF;
      default: m = 16'hFFFF;
    endcase
    return m << offs;
  endfunction

endpackage

// File: rtl/tl_resp_queue.sv
// Two-entry response FIFO between the A-side decode and the D channel.
// No bypass: a full queue refuses input even while it is being drained.
module tl_resp_queue
  import tl_ul_pkg::*;
(
  input  logic    clock,
  input  logic    reset_n,
  input  logic    i_valid,
  output logic    o_ready,
  input  tl_rsp_t i_entry,
  output logic    o_valid,
  input  logic    i_ready,
  output tl_rsp_t o_entry
);

  tl_rsp_t    r_mem [2];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_ready = (r_count != 2'd2);
  assign o_valid = (r_count != 2'd0);
  assign o_entry = r_mem[r_rptr];
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;

  // Pointer/count update; reset drops everything queued.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_entry;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL manager: legality check, word SRAM, in-order D responses.
// Macro TL_RESP_HINT_EN enables HintAck for opcode 5.
module tl_ul_sram_responder
  import tl_ul_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = TL_DATA_W,
  parameter int SOURCE_W  = TL_SOURCE_W,
  parameter int MEM_WORDS = 64
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [2:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [DATA_W/8-1:0] a_mask,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                a_corrupt,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [1:0]          d_param,
  output logic [2:0]          d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_sink,
  output logic                d_denied,
  output logic [DATA_W-1:0]   d_data,
  output logic                d_corrupt
);

  localparam int LANES  = DATA_W / 8;
  localparam int OFF_W  = $clog2(LANES);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int MIDX_W = $clog2(MEM_WORDS);

`ifdef TL_RESP_HINT_EN
  localparam bit HINT_EN = 1'b1;
`else
  localparam bit HINT_EN = 1'b0;
`endif

  logic [DATA_W-1:0] r_mem [MEM_WORDS];

  logic                    w_fire;
  logic [IDX_W-1:0]        w_idx;
  logic [MIDX_W-1:0]       w_midx;
  logic                    w_in_range;
  logic [TL_MAX_LANES-1:0] w_lane_full;
  logic [LANES-1:0]        w_lane;
  logic                    w_spill;
  logic [2:0]              w_lo;
  logic                    w_misalign;
  logic                    w_is_pf;
  logic                    w_is_pp;
  logic                    w_is_get;
  logic                    w_is_hint;
  logic                    w_is_put;
  logic                    w_op_ok;
  logic                    w_param_ok;
  logic                    w_mask_ok;
  logic                    w_denied;
  tl_rsp_t                 w_rsp;
  tl_rsp_t                 w_head;
  logic                    w_q_valid;

  assign w_fire = a_valid & a_ready;

  // Index is never wrapped: out-of-range upper bits are denied.
  assign w_idx      = a_address[ADDR_W-1:OFF_W];
  assign w_midx     = w_idx[MIDX_W-1:0];
  assign w_in_range = (w_idx < IDX_W'(MEM_WORDS));

  assign w_lane_full = lane_mask(a_size, 4'(a_address[OFF_W-1:0]));
  assign w_lane      = w_lane_full[LANES-1:0];
  assign w_spill     = |w_lane_full[TL_MAX_LANES-1:LANES];

  assign w_lo       = a_address[2:0] & ((3'd1 << a_size) - 3'd1);
  assign w_misalign = |w_lo;

  // Opcode classification.
  always_comb begin
    w_is_pf   = 1'b0;
    w_is_pp   = 1'b0;
    w_is_get  = 1'b0;
    w_is_hint = 1'b0;
    w_op_ok   = 1'b0;
    case (a_opcode)
      A_PUT_FULL: begin
        w_is_pf = 1'b1;
        w_op_ok = 1'b1;
      end
      A_PUT_PARTIAL: begin
        w_is_pp = 1'b1;
        w_op_ok = 1'b1;
      end
      A_GET: begin
        w_is_get = 1'b1;
        w_op_ok  = 1'b1;
      end
      A_HINT: begin
        w_is_hint = 1'b1;
        w_op_ok   = HINT_EN;
      end
      default: w_op_ok = 1'b0;
    endcase
  end

  assign w_is_put   = w_is_pf | w_is_pp;
  assign w_param_ok = (a_param == 3'd0) ||
                      (HINT_EN && w_is_hint && a_param == 3'd1);
  assign w_mask_ok  = w_is_pp ? ((a_mask & ~w_lane) == '0)
                              : (a_mask == w_lane);

  assign w_denied = !w_op_ok | !w_param_ok | (a_size > 3'd2) |
                    w_misalign | !w_in_range | !w_mask_ok |
                    w_spill | (w_is_put & a_corrupt);

  // Response entry built in the A fire cycle; Get data sampled here.
  always_comb begin
    w_rsp        = '0;
    w_rsp.size   = a_size;
    w_rsp.source = a_source;
    w_rsp.denied = w_denied;
    if (w_is_get) begin
      w_rsp.opcode = D_ACK_DATA;
    end else if (w_is_hint && !w_denied) begin
      w_rsp.opcode = D_HINT_ACK;
    end else begin
      w_rsp.opcode = D_ACK;
    end
    if (w_is_get && !w_denied) begin
      w_rsp.data = r_mem[w_midx];
    end
  end

  // SRAM byte-lane writes; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (w_fire && w_is_put && !w_denied) begin
      for (int i = 0; i < LANES; i++) begin
        if (a_mask[i]) begin
          r_mem[w_midx][8*i +: 8] <= a_data[8*i +: 8];
        end
      end
    end
  end

  tl_resp_queue u_queue (
    .clock   (clock),
    .reset_n (reset_n),
    .i_valid (a_valid),
    .o_ready (a_ready),
    .i_entry (w_rsp),
    .o_valid (w_q_valid),
    .i_ready (d_ready),
    .o_entry (w_head)
  );

  assign d_valid   = w_q_valid;
  assign d_opcode  = w_q_valid ? w_head.opcode : 3'd0;
  assign d_param   = 2'd0;
  assign d_size    = w_q_valid ? w_head.size : 3'd0;
  assign d_source  = w_q_valid ? w_head.source : '0;
  assign d_sink    = 1'b0;
  assign d_denied  = w_q_valid & w_head.denied;
  assign d_data    = w_q_valid ? w_head.data : '0;
  assign d_corrupt = w_q_valid & w_head.denied &
                     (w_head.opcode == D_ACK_DATA);

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// Directed bench for tl_ul_sram_responder.
// Hint expectations follow TL_RESP_HINT_EN.
module tb_tl_ul_sram_responder;
  import tl_ul_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  a_opcode = 3'd0;
  logic [2:0]  a_param = 3'd0;
  logic [2:0]  a_size = 3'd0;
  logic [4:0]  a_source = 5'd0;
  logic [13:0] a_address = 14'd0;
  logic [3:0]  a_mask = 4'd0;
  logic [31:0] a_data = 32'd0;
  logic        a_corrupt = 1'b0;
  logic        d_valid;
  logic        d_ready = 1'b1;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [2:0]  d_size;
  logic [4:0]  d_source;
  logic        d_sink;
  logic        d_denied;
  logic [31:0] d_data;
  logic        d_corrupt;

  int errs = 0;
  int checks = 0;

  tl_ul_sram_responder dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_opcode  (a_opcode),
    .a_param   (a_param),
    .a_size    (a_size),
    .a_source  (a_source),
    .a_address (a_address),
    .a_mask    (a_mask),
    .a_data    (a_data),
    .a_corrupt (a_corrupt),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .d_opcode  (d_opcode),
    .d_param   (d_param),
    .d_size    (d_size),
    .d_source  (d_source),
    .d_sink    (d_sink),
    .d_denied  (d_denied),
    .d_data    (d_data),
    .d_corrupt (d_corrupt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [2:0] par,
                      input logic [2:0] sz, input logic [4:0] src,
                      input logic [13:0] addr, input logic [3:0] msk,
                      input logic [31:0] dat, input logic cor);
    int n;
    n = 0;
    @(negedge clock);
    a_opcode  = op;
    a_param   = par;
    a_size    = sz;
    a_source  = src;
    a_address = addr;
    a_mask    = msk;
    a_data    = dat;
    a_corrupt = cor;
    a_valid   = 1'b1;
    while (!a_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!a_ready) begin
      check("a_ready_timeout", 32'(a_ready), 32'd1);
      a_valid = 1'b0;
    end else begin
      @(posedge clock);
      #1 a_valid = 1'b0;
    end
  endtask

  task automatic recv(input string tag, input logic [2:0] op,
                      input logic den, input logic [4:0] src,
                      input logic [2:0] sz, input logic [31:0] dat);
    int n;
    n = 0;
    @(negedge clock);
    while (!d_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_valid"}, 32'(d_valid), 32'd1);
    check({tag, "_op"}, 32'(d_opcode), 32'(op));
    check({tag, "_den"}, 32'(d_denied), 32'(den));
    check({tag, "_src"}, 32'(d_source), 32'(src));
    check({tag, "_size"}, 32'(d_size), 32'(sz));
    check({tag, "_data"}, d_data, dat);
    check({tag, "_corr"}, 32'(d_corrupt),
          32'(op == D_ACK_DATA && den));
    check({tag, "_param"}, 32'(d_param), 32'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("rst_dvalid", 32'(d_valid), 32'd0);
    check("rst_aready", 32'(a_ready), 32'd1);
    check("rst_dop", 32'(d_opcode), 32'd0);
    check("rst_ddata", d_data, 32'd0);
    reset_n = 1'b1;

    send(A_PUT_FULL, 3'd0, 3'd2, 5'd3, 14'h10, 4'hF, 32'hDEADBEEF, 1'b0);
    recv("pf", D_ACK, 1'b0, 5'd3, 3'd2, 32'd0);
    send(A_GET, 3'd0, 3'd2, 5'd7, 14'h10, 4'hF, 32'd0, 1'b0);
    recv("get1", D_ACK_DATA, 1'b0, 5'd7, 3'd2, 32'hDEADBEEF);

    send(A_PUT_PARTIAL, 3'd0, 3'd2, 5'd5, 14'h10, 4'h2,
         32'h0000AA00, 1'b0);
    recv("pp", D_ACK, 1'b0, 5'd5, 3'd2, 32'd0);
    send(A_GET, 3'd0, 3'd2, 5'd6, 14'h10, 4'hF, 32'd0, 1'b0);
    recv("get2", D_ACK_DATA, 1'b0, 5'd6, 3'd2, 32'hDEADAAEF);

    send(A_GET, 3'd0, 3'd2, 5'd8, 14'h100, 4'hF, 32'd0, 1'b0);
    recv("oob", D_ACK_DATA, 1'b1, 5'd8, 3'd2, 32'd0);
    send(A_GET, 3'd0, 3'd1, 5'd9, 14'h11, 4'h6, 32'd0, 1'b0);
    recv("misal", D_ACK_DATA, 1'b1, 5'd9, 3'd1, 32'd0);

    send(A_PUT_PARTIAL, 3'd0, 3'd0, 5'd1, 14'h13, 4'h8,
         32'h55000000, 1'b0);
    recv("byte", D_ACK, 1'b0, 5'd1, 3'd0, 32'd0);
    send(A_GET, 3'd0, 3'd1, 5'd2, 14'h12, 4'hC, 32'd0, 1'b0);
    recv("half", D_ACK_DATA, 1'b0, 5'd2, 3'd1, 32'h55ADAAEF);

    send(A_PUT_FULL, 3'd0, 3'd2, 5'd3, 14'h10, 4'hF, 32'd0, 1'b1);
    recv("pcorr", D_ACK, 1'b1, 5'd3, 3'd2, 32'd0);
    send(A_PUT_FULL, 3'd0, 3'd2, 5'd4, 14'h10, 4'h7, 32'd0, 1'b0);
    recv("pfmask", D_ACK, 1'b1, 5'd4, 3'd2, 32'd0);
    send(A_PUT_PARTIAL, 3'd0, 3'd1, 5'd5, 14'h10, 4'h4, 32'd0, 1'b0);
    recv("ppmask", D_ACK, 1'b1, 5'd5, 3'd1, 32'd0);
    send(A_GET, 3'd1, 3'd2, 5'd6, 14'h10, 4'hF, 32'd0, 1'b0);
    recv("param", D_ACK_DATA, 1'b1, 5'd6, 3'd2, 32'd0);
    send(A_GET, 3'd0, 3'd3, 5'd7, 14'h10, 4'hF, 32'd0, 1'b0);
    recv("size3", D_ACK_DATA, 1'b1, 5'd7, 3'd3, 32'd0);
    send(A_ARITH, 3'd0, 3'd2, 5'd8, 14'h10, 4'hF, 32'd0, 1'b0);
    recv("arith", D_ACK, 1'b1, 5'd8, 3'd2, 32'd0);
    send(A_GET, 3'd0, 3'd2, 5'd9, 14'h10, 4'hF, 32'd0, 1'b0);
    recv("nowr", D_ACK_DATA, 1'b0, 5'd9, 3'd2, 32'h55ADAAEF);

    send(A_PUT_FULL, 3'd0, 3'd2, 5'd4, 14'hFC, 4'hF, 32'h0BADF00D, 1'b0);
    recv("pftop", D_ACK, 1'b0, 5'd4, 3'd2, 32'd0);
    send(A_GET, 3'd0, 3'd2, 5'd4, 14'hFC, 4'hF, 32'd0, 1'b0);
    recv("gettop", D_ACK_DATA, 1'b0, 5'd4, 3'd2, 32'h0BADF00D);

    send(A_HINT, 3'd0, 3'd2, 5'd11, 14'h10, 4'hF, 32'd0, 1'b0);
`ifdef TL_RESP_HINT_EN
    recv("hint", D_HINT_ACK, 1'b0, 5'd11, 3'd2, 32'd0);
`else
    recv("hint", D_ACK, 1'b1, 5'd11, 3'd2, 32'd0);
`endif

    for (int k = 0; k < 4; k++) begin
      send(A_PUT_FULL, 3'd0, 3'd2, 5'd1, 14'(32'h20 + 4 * k), 4'hF,
           32'hA0A00000 | k, 1'b0);
      recv("pfb", D_ACK, 1'b0, 5'd1, 3'd2, 32'd0);
    end

    d_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          send(A_GET, 3'd0, 3'd2, 5'(10 + k), 14'(32'h20 + 4 * k), 4'hF,
               32'd0, 1'b0);
        end
      end
      begin
        repeat (4) @(negedge clock);
        check("full_aready", 32'(a_ready), 32'd0);
        check("hold_valid", 32'(d_valid), 32'd1);
        check("hold_src", 32'(d_source), 32'd10);
        check("hold_data", d_data, 32'hA0A00000);
        @(posedge clock);
        #1 d_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
          recv("b2b", D_ACK_DATA, 1'b0, 5'(10 + k), 3'd2,
               32'hA0A00000 | k);
        end
      end
    join
    @(negedge clock);
    check("drained", 32'(d_valid), 32'd0);

    d_ready = 1'b0;
    send(A_GET, 3'd0, 3'd2, 5'd1, 14'h10, 4'hF, 32'd0, 1'b0);
    send(A_GET, 3'd0, 3'd2, 5'd2, 14'h10, 4'hF, 32'd0, 1'b0);
    @(negedge clock);
    check("pre_rst_valid", 32'(d_valid), 32'd1);
    check("pre_rst_aready", 32'(a_ready), 32'd0);
    reset_n = 1'b0;
    @(negedge clock);
    check("mid_rst_valid", 32'(d_valid), 32'd0);
    check("mid_rst_src", 32'(d_source), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_aready", 32'(a_ready), 32'd1);
    check("post_rst_valid", 32'(d_valid), 32'd0);
    d_ready = 1'b1;
    send(A_GET, 3'd0, 3'd2, 5'd12, 14'h10, 4'hF, 32'd0, 1'b0);
    recv("post_rst", D_ACK_DATA, 1'b0, 5'd12, 3'd2, 32'h55ADAAEF);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
